// File: rtl/sha3_miner_pkg.sv
// Shared constants for the SHA3 miner CSR bank: word addresses of every
// register, CONTROL field layout and IRQCTL bit positions.
package sha3_miner_pkg;

   // Word addresses on the Avalon-MM slave
   localparam logic [4:0] ADDR_HEADER0    = 5'h00;
   localparam logic [4:0] ADDR_HEADER7    = 5'h07;
   localparam logic [4:0] ADDR_DIFF0      = 5'h08;
   localparam logic [4:0] ADDR_DIFF7      = 5'h0F;
   localparam logic [4:0] ADDR_NONCE_LO   = 5'h10;
   localparam logic [4:0] ADDR_NONCE_HI   = 5'h11;
   localparam logic [4:0] ADDR_CONTROL    = 5'h12;
   localparam logic [4:0] ADDR_STATUS     = 5'h13;
   localparam logic [4:0] ADDR_SOL_LO     = 5'h14;
   localparam logic [4:0] ADDR_SOL_HI     = 5'h15;
   localparam logic [4:0] ADDR_IRQCTL     = 5'h16;
   localparam logic [4:0] ADDR_ELAPSED_LO = 5'h17;
   localparam logic [4:0] ADDR_ELAPSED_HI = 5'h18;
   localparam logic [4:0] ADDR_ID         = 5'h19;

   // Last address of the block that is frozen while the engine runs
   localparam logic [4:0] ADDR_PROTECT_LAST = ADDR_NONCE_HI;

   // CONTROL field layout: [17:10] padf, [9:2] padl, [1] test, [0] run
   localparam int CTRL_WIDTH    = 18;
   localparam int CTRL_RUN_BIT  = 0;
   localparam int CTRL_TEST_BIT = 1;
   localparam int CTRL_PADL_LSB = 2;
   localparam int CTRL_PADF_LSB = 10;

   typedef struct packed {
      logic [7:0] padf;
      logic [7:0] padl;
      logic       test;
      logic       run;
   } control_t;

   // IRQCTL layout: bit0 enable (RW), bit1 write-one-to-clear pending
   localparam int IRQCTL_EN_BIT  = 0;
   localparam int IRQCTL_CLR_BIT = 1;

   // True for addresses holding engine inputs (header, difficulty, nonce)
   function automatic logic is_protected(input logic [4:0] addr);
      return (addr <= ADDR_PROTECT_LAST);
   endfunction

endpackage

// File: rtl/sha3_reset_sync.sv
// Two-flop reset synchroniser: asserts asynchronously with rst_n low and
// releases on the second rising clk edge after rst_n returns high.
module sha3_reset_sync (
   input  logic clk,
   input  logic rst_n,
   output logic sync_rst
);

   logic [1:0] stage;

   // Shift zeros in after release; both flops preset while rst_n is low
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage <= 2'b11;
      end else begin
         stage <= {stage[0], 1'b0};
      end
   end

   assign sync_rst = stage[1];

endmodule

// File: rtl/sha3_miner_csr.sv
// Control/status register bank for the SHA3-256 mining engine. Holds the
// engine's header, difficulty, start nonce and control words, captures the
// solution on the engine's IRQ edge, counts run cycles, and presents all of
// it on a 32-bit Avalon-MM slave with a single interrupt.
//
// Bus handshake: a read strobe in cycle N yields avs_readdata together with
// a one-cycle avs_readdatavalid pulse in cycle N+1; there is no wait-request,
// so every read and write is accepted in the cycle it is presented. The read
// data reflects register contents before any write issued in the same cycle.
module sha3_miner_csr
   import sha3_miner_pkg::*;
#(
   parameter logic [31:0] ID_VALUE  = 32'h5348_4133,
   parameter bit          AUTO_STOP = 1'b1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [4:0]   avs_address,
   input  logic         avs_write,
   input  logic [31:0]  avs_writedata,
   input  logic         avs_read,
   output logic [31:0]  avs_readdata,
   output logic         avs_readdatavalid,
   output logic         irq_out,
   output logic         miner_rst,
   output logic [255:0] header,
   output logic [255:0] difficulty,
   output logic [63:0]  start_nonce,
   output logic [17:0]  control,
   input  logic [63:0]  solution,
   input  logic [2:0]   status,
   input  logic         miner_irq
);

   // Register state
   logic [255:0] header_r;
   logic [255:0] diff_r;
   logic [63:0]  nonce_r;
   control_t     control_r;
   logic [63:0]  sol_r;
   logic         pending_r;
   logic         irq_en_r;
   logic         irq_out_r;
   logic         miner_irq_d;
   logic [63:0]  elapsed_r;
   logic [31:0]  elapsed_hi_hold;
   logic [31:0]  readdata_r;
   logic         readdatavalid_r;

   // Decoded strobes
   logic         irq_rise;
   logic         data_wr_ok;
   logic         ctrl_wr;
   logic         irqctl_wr;
   logic         irq_clr;
   logic         run_start;
   logic [7:0]   word_base;
   logic [31:0]  read_mux;

   // Engine reset follows the bus reset but releases synchronously
   sha3_reset_sync u_reset_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .sync_rst (miner_rst)
   );

   // Bit offset of the addressed 32-bit word within a 256-bit block
   assign word_base  = {avs_address[2:0], 5'b0_0000};

   assign irq_rise   = miner_irq & ~miner_irq_d;
   // Engine inputs are frozen while it is running so it never sees a torn value
   assign data_wr_ok = avs_write & is_protected(avs_address) & ~control_r.run;
   assign ctrl_wr    = avs_write & (avs_address == ADDR_CONTROL);
   assign irqctl_wr  = avs_write & (avs_address == ADDR_IRQCTL);
   assign irq_clr    = irqctl_wr & avs_writedata[IRQCTL_CLR_BIT];
   assign run_start  = ctrl_wr & ~control_r.run & avs_writedata[CTRL_RUN_BIT];

   // Read mux: combinational view of every register at the current address
   always_comb begin
      read_mux = 32'h0;
      if (avs_address <= ADDR_HEADER7) begin
         read_mux = header_r[word_base +: 32];
      end else if (avs_address <= ADDR_DIFF7) begin
         read_mux = diff_r[word_base +: 32];
      end else begin
         case (avs_address)
            ADDR_NONCE_LO:   read_mux = nonce_r[31:0];
            ADDR_NONCE_HI:   read_mux = nonce_r[63:32];
            ADDR_CONTROL:    read_mux = {14'h0, control_r};
            ADDR_STATUS:     read_mux = {28'h0, pending_r, status};
            ADDR_SOL_LO:     read_mux = sol_r[31:0];
            ADDR_SOL_HI:     read_mux = sol_r[63:32];
            ADDR_IRQCTL:     read_mux = {31'h0, irq_en_r};
            ADDR_ELAPSED_LO: read_mux = elapsed_r[31:0];
            // High half comes from the snapshot taken by the last low-half read
            ADDR_ELAPSED_HI: read_mux = elapsed_hi_hold;
            ADDR_ID:         read_mux = ID_VALUE;
            default:         read_mux = 32'h0;
         endcase
      end
   end

   // All CSR state: bus writes, solution capture, IRQ, run counter, read port
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         header_r        <= '0;
         diff_r          <= '0;
         nonce_r         <= '0;
         control_r       <= '0;
         sol_r           <= '0;
         pending_r       <= 1'b0;
         irq_en_r        <= 1'b0;
         irq_out_r       <= 1'b0;
         miner_irq_d     <= 1'b0;
         elapsed_r       <= '0;
         elapsed_hi_hold <= '0;
         readdata_r      <= '0;
         readdatavalid_r <= 1'b0;
      end else begin
         miner_irq_d <= miner_irq;

         // Engine input words, writable only while stopped
         if (data_wr_ok) begin
            if (avs_address <= ADDR_HEADER7) begin
               header_r[word_base +: 32] <= avs_writedata;
            end else if (avs_address <= ADDR_DIFF7) begin
               diff_r[word_base +: 32] <= avs_writedata;
            end else if (avs_address == ADDR_NONCE_LO) begin
               nonce_r[31:0] <= avs_writedata;
            end else begin
               nonce_r[63:32] <= avs_writedata;
            end
         end

         if (ctrl_wr) begin
            control_r <= avs_writedata[CTRL_WIDTH-1:0];
         end

         if (irqctl_wr) begin
            irq_en_r <= avs_writedata[IRQCTL_EN_BIT];
         end

         if (irq_clr) begin
            pending_r <= 1'b0;
         end

         // Capture is placed after the bus updates so a simultaneous W1C or
         // CONTROL write cannot hide a freshly found solution
         if (irq_rise) begin
            sol_r     <= solution;
            pending_r <= 1'b1;
            if (AUTO_STOP) begin
               control_r.run <= 1'b0;
            end
         end

         irq_out_r <= pending_r & irq_en_r;

         // Run-cycle counter: restarts on a 0->1 run transition, saturates
         if (run_start) begin
            elapsed_r <= '0;
         end else if (control_r.run && !miner_irq && (elapsed_r != '1)) begin
            elapsed_r <= elapsed_r + 64'd1;
         end

         readdatavalid_r <= avs_read;
         if (avs_read) begin
            readdata_r <= read_mux;
            if (avs_address == ADDR_ELAPSED_LO) begin
               elapsed_hi_hold <= elapsed_r[63:32];
            end
         end
      end
   end

   assign header            = header_r;
   assign difficulty        = diff_r;
   assign start_nonce       = nonce_r;
   assign control           = control_r;
   assign irq_out           = irq_out_r;
   assign avs_readdata      = readdata_r;
   assign avs_readdatavalid = readdatavalid_r;

endmodule

// File: tb/tb_sha3_miner_csr.sv
// Directed bench for sha3_miner_csr. Reads push their expected data into a
// queue; a monitor on the falling edge pops and compares whenever the DUT
// presents readdatavalid. Non-bus outputs are checked directly.
module tb_sha3_miner_csr;
   import sha3_miner_pkg::*;

   logic         clk;
   logic         rst_n;
   logic [4:0]   avs_address;
   logic         avs_write;
   logic [31:0]  avs_writedata;
   logic         avs_read;
   logic [31:0]  avs_readdata;
   logic         avs_readdatavalid;
   logic         irq_out;
   logic         miner_rst;
   logic [255:0] header;
   logic [255:0] difficulty;
   logic [63:0]  start_nonce;
   logic [17:0]  control;
   logic [63:0]  solution;
   logic [2:0]   status;
   logic         miner_irq;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] exp_q[$];
   string       name_q[$];
   logic        read_seen;

   sha3_miner_csr dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .avs_address       (avs_address),
      .avs_write         (avs_write),
      .avs_writedata     (avs_writedata),
      .avs_read          (avs_read),
      .avs_readdata      (avs_readdata),
      .avs_readdatavalid (avs_readdatavalid),
      .irq_out           (irq_out),
      .miner_rst         (miner_rst),
      .header            (header),
      .difficulty        (difficulty),
      .start_nonce       (start_nonce),
      .control           (control),
      .solution          (solution),
      .status            (status),
      .miner_irq         (miner_irq)
   );

   // Clock and watchdog
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   // Remember which cycles carried an accepted read strobe
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) read_seen <= 1'b0;
      else        read_seen <= avs_read;
   end

   // Scoreboard monitor
   always @(negedge clk) begin
      logic [31:0] exp_v;
      string       nm;
      if (read_seen || avs_readdatavalid) begin
         n_tests++;
         if (!avs_readdatavalid) begin
            n_fail++;
            nm = (name_q.size() != 0) ? name_q.pop_front() : "unnamed";
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            $display("FAIL %s: readdatavalid got 0 required 1", nm);
         end else if (!read_seen) begin
            n_fail++;
            $display("FAIL rd_spurious: readdatavalid got 1 required 0");
         end else if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL rd_unexpected: readdata %08h with no expectation queued", avs_readdata);
         end else begin
            exp_v = exp_q.pop_front();
            nm    = name_q.pop_front();
            if (avs_readdata !== exp_v) begin
               n_fail++;
               $display("FAIL %s: readdata got %08h required %08h", nm, avs_readdata, exp_v);
            end
         end
      end
   end

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp_v);
      n_tests++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", name, act, exp_v);
      end
   endtask

   // Driver tasks: called at a falling edge, each occupies one clock
   task automatic bus_write(input logic [4:0] addr, input logic [31:0] data);
      avs_address   = addr;
      avs_writedata = data;
      avs_write     = 1'b1;
      @(negedge clk);
      avs_write     = 1'b0;
   endtask

   task automatic bus_read(input logic [4:0] addr, input logic [31:0] exp_v, input string name);
      avs_address = addr;
      avs_read    = 1'b1;
      exp_q.push_back(exp_v);
      name_q.push_back(name);
      @(negedge clk);
      avs_read    = 1'b0;
   endtask

   task automatic bus_rw(input logic [4:0] addr, input logic [31:0] data,
                         input logic [31:0] exp_v, input string name);
      avs_address   = addr;
      avs_writedata = data;
      avs_write     = 1'b1;
      avs_read      = 1'b1;
      exp_q.push_back(exp_v);
      name_q.push_back(name);
      @(negedge clk);
      avs_write     = 1'b0;
      avs_read      = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      rst_n         = 1'b0;
      avs_address   = '0;
      avs_write     = 1'b0;
      avs_writedata = '0;
      avs_read      = 1'b0;
      solution      = '0;
      status        = 3'b101;
      miner_irq     = 1'b0;

      // Reset values
      idle(2);
      check("rst_miner_rst", miner_rst, 1'b1);
      check("rst_irq_out", irq_out, 1'b0);
      check("rst_control", control, 18'h0);
      check("rst_header", header, 256'h0);
      check("rst_rdvalid", avs_readdatavalid, 1'b0);

      // Release: miner_rst falls on the second rising edge
      rst_n = 1'b1;
      @(negedge clk);
      check("miner_rst_edge1", miner_rst, 1'b1);
      @(negedge clk);
      check("miner_rst_edge2", miner_rst, 1'b0);
      bus_read(ADDR_ID, 32'h5348_4133, "id");
      check("post_rst_difficulty", difficulty, 256'h0);
      check("post_rst_nonce", start_nonce, 64'h0);

      // Engine input registers while stopped
      bus_write(ADDR_HEADER0, 32'hDEAD_BEEF);
      bus_write(ADDR_HEADER7, 32'h0123_4567);
      check("header_w0", header[31:0], 32'hDEAD_BEEF);
      check("header_w7", header[255:224], 32'h0123_4567);
      bus_write(ADDR_DIFF0, 32'hCAFE_F00D);
      bus_write(ADDR_NONCE_LO, 32'h1111_1111);
      bus_write(ADDR_NONCE_HI, 32'h2222_2222);
      check("diff_w0", difficulty[31:0], 32'hCAFE_F00D);
      check("nonce", start_nonce, 64'h2222_2222_1111_1111);
      bus_read(ADDR_HEADER7, 32'h0123_4567, "rd_header7");
      bus_read(ADDR_NONCE_HI, 32'h2222_2222, "rd_nonce_hi");

      // CONTROL fields: padf=A5 padl=3C test=1 run=0, upper bits dropped
      bus_write(ADDR_CONTROL, 32'hFFFE_94F2);
      check("control_fields", control, 18'h294F2);
      bus_read(ADDR_CONTROL, 32'h0002_94F2, "rd_control");

      // Start the run (edge P0 clears ELAPSED); protected writes ignored
      bus_write(ADDR_CONTROL, 32'h0000_0001);
      bus_write(ADDR_HEADER0, 32'h0000_0000);
      check("header_protected", header[31:0], 32'hDEAD_BEEF);
      bus_write(ADDR_NONCE_LO, 32'hFFFF_FFFF);
      check("nonce_protected", start_nonce, 64'h2222_2222_1111_1111);
      idle(97);
      // Read sampled at the 100th edge after P0 returns the count before it: 99
      bus_read(ADDR_ELAPSED_LO, 32'd99, "elapsed_lo_run");
      bus_read(ADDR_ELAPSED_HI, 32'd0, "elapsed_hi_run");

      // Solution capture with IRQ enabled
      bus_write(ADDR_IRQCTL, 32'h0000_0001);
      solution  = 64'h0000_0001_0000_002A;
      miner_irq = 1'b1;
      @(negedge clk);
      check("auto_stop_run", control[0], 1'b0);
      check("irq_out_delay", irq_out, 1'b0);
      @(negedge clk);
      check("irq_out_set", irq_out, 1'b1);
      bus_read(ADDR_SOL_LO, 32'h0000_002A, "sol_lo");
      bus_read(ADDR_SOL_HI, 32'h0000_0001, "sol_hi");
      bus_read(ADDR_STATUS, 32'h0000_000D, "status_pending");
      // Counter counted 102 cycles and stopped when miner_irq rose
      bus_read(ADDR_ELAPSED_LO, 32'd102, "elapsed_frozen");
      bus_read(ADDR_CONTROL, 32'h0, "control_after_stop");

      // W1C colliding with a new capture edge keeps pending set
      miner_irq = 1'b0;
      @(negedge clk);
      solution  = 64'hAAAA_BBBB_CCCC_DDDD;
      miner_irq = 1'b1;
      bus_write(ADDR_IRQCTL, 32'h0000_0003);
      check("collide_irq_a", irq_out, 1'b1);
      @(negedge clk);
      check("collide_irq_b", irq_out, 1'b1);
      bus_read(ADDR_SOL_LO, 32'hCCCC_DDDD, "sol_overwrite_lo");
      bus_read(ADDR_SOL_HI, 32'hAAAA_BBBB, "sol_overwrite_hi");
      bus_read(ADDR_IRQCTL, 32'h0000_0001, "irqctl_rd");

      // Plain W1C: irq_out falls one cycle after pending clears
      bus_write(ADDR_IRQCTL, 32'h0000_0003);
      check("w1c_irq_hold", irq_out, 1'b1);
      @(negedge clk);
      check("w1c_irq_fall", irq_out, 1'b0);
      bus_read(ADDR_STATUS, 32'h0000_0005, "status_cleared");

      // Writable again once stopped; read/write collision returns old data
      bus_write(ADDR_HEADER0 + 5'd1, 32'hAAAA_5555);
      bus_rw(ADDR_HEADER0 + 5'd1, 32'h0F0F_0F0F, 32'hAAAA_5555, "rw_old_value");
      bus_read(ADDR_HEADER0 + 5'd1, 32'h0F0F_0F0F, "rw_new_value");
      check("header_w1", header[63:32], 32'h0F0F_0F0F);
      bus_write(5'h1A, 32'hFFFF_FFFF);
      bus_read(5'h1A, 32'h0, "unmapped");

      // Reset in the middle of a read
      miner_irq = 1'b0;
      bus_write(ADDR_CONTROL, 32'h0000_0005);
      check("control_pre_reset", control, 18'h5);
      avs_address = ADDR_CONTROL;
      avs_read    = 1'b1;
      #2 rst_n    = 1'b0;
      #1;
      check("midrst_miner_rst", miner_rst, 1'b1);
      check("midrst_control", control, 18'h0);
      @(negedge clk);
      avs_read = 1'b0;
      check("midrst_no_valid", avs_readdatavalid, 1'b0);
      rst_n = 1'b1;
      idle(3);
      check("midrst_miner_rst_rel", miner_rst, 1'b0);
      bus_read(ADDR_CONTROL, 32'h0, "control_after_rst");
      bus_read(ADDR_HEADER0, 32'h0, "header_after_rst");

      idle(3);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
